// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: walks an inclusive range of architectural registers
// through one register-file read port. Each word is streamed with its index
// over a valid/ready interface.
//
// Handshake: dump_valid rises once a word is captured. While dump_valid is
// high, dump_data, dump_index and dump_last are held stable. A word transfers
// on a rising edge where dump_valid && dump_ready. dump_valid never depends
// combinationally on dump_ready.
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_sel,
  input  logic [ADDR_W-1:0] last_sel,
  input  logic              abort,
  output logic [ADDR_W-1:0] read_sel,
  input  logic [DATA_W-1:0] read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Highest legal register index. A last_sel beyond it is rejected like an
  // inverted range, so a walk can never address a register that does not exist.
  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;

  // read_sel comes straight from the idx register, so it cannot glitch.
  assign read_sel  = idx;
  assign fsm_state = state;

  // Dump sequencer: range latch, fetch/capture, handshake and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      last_q     <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      done      <= 1'b0;
      range_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((first_sel > last_sel) || (last_sel > MAX_IDX)) begin
              done      <= 1'b1;
              range_err <= 1'b1;
            end else begin
              idx    <= first_sel;
              last_q <= last_sel;
              busy   <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dump_data  <= read_data;
            dump_index <= idx;
            dump_last  <= (idx == last_q);
            dump_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a handshake in the same cycle.
          if (abort) begin
            dump_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // The last==idx test stops the walk at 31, so this never wraps.
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: a behavioural register file plus a model that
// lists the expected word sequence for a range, one task per scenario.
module tb_regfile_dump_unit;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int W      = 1 + ADDR_W + DATA_W;

  logic              clock;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_sel;
  logic [ADDR_W-1:0] last_sel;
  logic              abort;
  logic [ADDR_W-1:0] read_sel;
  logic [DATA_W-1:0] read_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_last;
  logic              busy;
  logic              done;
  logic              range_err;
  logic [1:0]        fsm_state;

  logic [DATA_W-1:0] regs [32];

  int checks;
  int failures;
  int cyc;
  int t0;

  // Monitor results for the most recent run
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  int done_cnt, done_at, re_cnt, re_at, stab_bad, busy_bad;
  bit busy_seen, valid_seen;

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .start(start), .first_sel(first_sel),
    .last_sel(last_sel), .abort(abort), .read_sel(read_sel),
    .read_data(read_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
    .busy(busy), .done(done), .range_err(range_err), .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model: x0 is hard-wired to zero
  assign read_data = (read_sel == '0) ? '0 : regs[read_sel];

  // Expected word list for an inclusive range: {last, index, data}
  task automatic build_exp(input int f, input int l);
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      logic [DATA_W-1:0] d;
      d = (i == 0) ? '0 : regs[i];
      exp_q.push_back({(i == l), ADDR_W'(i), d});
    end
  endtask

  task automatic do_start(input int f, input int l);
    @(negedge clock);
    first_sel = ADDR_W'(f);
    last_sel  = ADDR_W'(l);
    start     = 1'b1;
    t0        = cyc;
  endtask

  // Drives dump_ready (fixed stall or random) and records every transfer.
  task automatic run_dump(input int max_cyc, input int stall, input bit rnd);
    logic [W-1:0] hold;
    bit holding;
    int left;
    got_q.delete();
    done_cnt = 0; done_at = -1; re_cnt = 0; re_at = -1;
    stab_bad = 0; busy_bad = 0; busy_seen = 0; valid_seen = 0;
    holding = 0; left = 0; hold = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clock);
      if (done) begin
        done_cnt++;
        done_at = cyc - t0;
        if (busy) busy_bad++;
      end
      if (range_err) begin
        re_cnt++;
        re_at = cyc - t0;
      end
      if (busy) busy_seen = 1;
      if (dump_valid) begin
        valid_seen = 1;
        if (!busy) busy_bad++;
        if (!holding) begin
          hold    = {dump_last, dump_index, dump_data};
          holding = 1;
          left    = rnd ? int'($urandom_range(0, 3)) : stall;
        end else if ({dump_last, dump_index, dump_data} !== hold) begin
          stab_bad++;
        end
        if (left == 0) begin
          dump_ready = 1'b1;
          got_q.push_back(hold);
          holding = 0;
        end else begin
          dump_ready = 1'b0;
          left--;
        end
      end else begin
        dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      // Start and abort noise only where they must be ignored
      start = rnd && (fsm_state != 2'd0) && ($urandom_range(0, 3) == 0);
      abort = rnd && (fsm_state == 2'd3) && ($urandom_range(0, 1) == 0);
      if (start) begin
        first_sel = ADDR_W'($urandom);
        last_sel  = ADDR_W'($urandom);
      end
      if (done_at >= 0 && (cyc - t0) > done_at + 1) break;
    end
    start = 1'b0;
    abort = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (read_sel !== '0) begin failures++; $display("FAIL reset_read_sel got=%0h exp=0", read_sel); end
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dump_valid); end
    checks++; if (dump_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", dump_data); end
    checks++; if (dump_index !== '0) begin failures++; $display("FAIL reset_index got=%0h exp=0", dump_index); end
    checks++; if ({dump_last, busy, done, range_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dump_last, busy, done, range_err}); end
    reset = 1'b0;
  endtask

  task automatic test_full_dump;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | i;
    build_exp(0, 31);
    do_start(0, 31);
    run_dump(120, 0, 0);
    checks++; if (got_q.size() != 32) begin failures++; $display("FAIL full_count got=%0d exp=32", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL full_word%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_at != 65) begin failures++; $display("FAIL full_done_time got=%0d exp=65", done_at); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL full_busy got=%0d exp=0", busy_bad); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    build_exp(5, 7);
    do_start(5, 7);
    run_dump(100, 3, 0);
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_word%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_bad); end
    checks++; if (done_at != 16) begin failures++; $display("FAIL bp_done_time got=%0d exp=16", done_at); end
  endtask

  task automatic test_single;
    regs[10] = 32'hDEAD_BEEF;
    do_start(10, 10);
    run_dump(30, 0, 0);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== {1'b1, 5'd10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL single_word got=%0h exp=%0h", (got_q.size() > 0) ? got_q[0] : '0, {1'b1, 5'd10, 32'hDEAD_BEEF});
    end
    checks++; if (done_cnt != 1 || done_at != 3) begin failures++; $display("FAIL single_done got=%0d@%0d exp=1@3", done_cnt, done_at); end
  endtask

  task automatic test_bad_range;
    do_start(12, 3);
    run_dump(10, 0, 0);
    checks++; if (valid_seen) begin failures++; $display("FAIL bad_valid got=1 exp=0"); end
    checks++; if (busy_seen) begin failures++; $display("FAIL bad_busy got=1 exp=0"); end
    checks++; if (done_cnt != 1 || done_at != 1) begin failures++; $display("FAIL bad_done got=%0d@%0d exp=1@1", done_cnt, done_at); end
    checks++; if (re_cnt != 1 || re_at != 1) begin failures++; $display("FAIL bad_range_err got=%0d@%0d exp=1@1", re_cnt, re_at); end
  endtask

  task automatic test_abort;
    int n;
    bit hit;
    bit saw_done;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    n = 0; hit = 0; saw_done = 0;
    do_start(0, 31);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      start = 1'b0;
      dump_ready = 1'b1;
      if (dump_valid) begin
        if (dump_index == 5'd4) begin
          abort = 1'b1;
          hit = 1;
        end else begin
          n++;
        end
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL abort_reach got=0 exp=1"); end
    checks++; if (n != 4) begin failures++; $display("FAIL abort_words got=%0d exp=4", n); end
    @(negedge clock);
    abort = 1'b0;
    dump_ready = 1'b0;
    checks++; if (dump_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_next got=%b%b exp=00", dump_valid, busy); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", fsm_state); end
    if (done) saw_done = 1;
    repeat (5) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL abort_done got=1 exp=0"); end
    do_start(2, 2);
    run_dump(30, 0, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 5'd2, regs[2]}) begin
      failures++;
      $display("FAIL abort_restart got=%0d:%0h exp=1:%0h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {1'b1, 5'd2, regs[2]});
    end
  endtask

  task automatic test_reset_mid_dump;
    bit hit;
    bit saw_done;
    hit = 0; saw_done = 0;
    do_start(0, 31);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      start = 1'b0;
      dump_ready = 1'b0;
      if (dump_valid) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({read_sel, dump_data, dump_index, dump_valid, dump_last, busy, done, range_err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%0h/%0h/%0h/%b%b%b%b%b exp=all0",
               read_sel, dump_data, dump_index, dump_valid, dump_last, busy, done, range_err);
    end
    repeat (10) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL rst_mid_done got=1 exp=0"); end
  endtask

  task automatic test_random_ranges;
    for (int t = 0; t < 8; t++) begin
      int f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      build_exp(f, l);
      do_start(f, l);
      run_dump(200, 0, 1);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_count got=%0d exp=%0d", t, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rnd%0d_word%0d got=%0h exp=%0h", t, i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=1", t, done_cnt); end
      checks++; if (stab_bad != 0 || busy_bad != 0) begin failures++; $display("FAIL rnd%0d_proto got=%0d/%0d exp=0/0", t, stab_bad, busy_bad); end
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    first_sel = '0; last_sel = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset;
    test_full_dump;
    test_backpressure;
    test_single;
    test_bad_range;
    test_abort;
    test_reset_mid_dump;
    test_random_ranges;
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
